spi_slave_trx: RTL and testbench
================================

# spi_slave_trx

Synthesizable SPI target (slave) endpoint: the opposite end of the bus driven by `spi_intface`, suitable for FPGA designs that answer an on-board SPI master. It oversamples SCK, MOSI and CS_B in the `S_SYSCLK` domain and supports all four CPOL/CPHA modes, MSB- or LSB-first order, and character lengths of 4–16 bits. The user logic side has one-deep TX and RX holding registers with valid/ready handshakes, plus overrun and underrun flags.

## Interface
- `CHAR_NBITS`, 16: maximum character width, and the width of the TX/RX data ports.
- `SYNC_STAGES`, 2: synchronizer depth on SCK, MOSI and CS_B; minimum value 2.

- `S_SYSCLK` in 1: system clock; single clock domain.
- `S_RESET` in 1: reset, synchronous, active-high.
- `S_ENABLE` in 1: block enable. 0 forces IDLE and clears both holding-valid flags.
- `S_CPOL` in 1: SCK idle level.
- `S_CPHA` in 1: 0 = sample on the leading edge; 1 = sample on the trailing edge.
- `S_REV` in 1: 1 = MSB first, 0 = LSB first.
- `S_CHAR_LEN` in 4: character bits minus 1; legal range 3..15.
- `S_SPI_SCK` in 1: bus clock, asynchronous to `S_SYSCLK`.
- `S_SPI_MOSI` in 1: master-out data.
- `S_SPI_CS_B` in 1: chip select, active-low.
- `S_SPI_MISO` out 1: slave-out data.
- `S_SPI_MISO_OE` out 1: MISO output enable; the top level tri-states the pad when this is 0.
- `S_TX_DATA` in CHAR_NBITS: next character to send, right-justified.
- `S_TX_VALID` in 1: TX handshake valid.
- `S_TX_READY` out 1: TX holding register is empty.
- `S_RX_DATA` out CHAR_NBITS: received character, right-justified, upper bits zero.
- `S_RX_VALID` out 1: RX holding register is full.
- `S_RX_READY` in 1: consumer accepts the RX character.
- `S_OVERRUN` out 1: one-cycle pulse when a completed character is dropped.
- `S_UNDERRUN` out 1: one-cycle pulse when a character load finds TX empty.
- `S_BUSY` out 1: CS active and the state machine is not in IDLE.

## Operation
- **Synchronization and edge detect**
  - Each bus input passes through `SYNC_STAGES` flops.
  - Edges are detected by comparing the last synchronizer stage with one history flop.
  - Leading edge = SCK leaves the `S_CPOL` level; trailing edge = SCK returns to it.
  - Sample edge = leading if `S_CPHA`=0, trailing if `S_CPHA`=1. Shift edge = the other one.
- **State machine**
  - IDLE → ACTIVE on a synchronized CS_B falling edge while `S_ENABLE`=1.
  - ACTIVE → IDLE on CS_B rising, `S_ENABLE`=0, or `S_RESET`.
- **Load point**: the moment a character's first bit is driven.
  - `S_CPHA`=0: the first character loads on CS fall. Each following character loads on the shift edge after the previous character's last sample.
  - `S_CPHA`=1: every character loads on its first shift edge.
- **Loading**
  - At the load point, the TX holding register moves into the shift register and `S_TX_READY` returns to 1.
  - If the holding register is empty, the shift register loads all ones and `S_UNDERRUN` pulses.
- **Shifting**: MISO presents the next bit on each shift edge; the load point presents the first bit.
- **Bit order**: `S_REV`=1 transmits bit `S_CHAR_LEN` down to bit 0; `S_REV`=0 transmits bit 0 upward. RX assembly uses the same order.
- **Bit counter**
  - Counts sample edges from 0 to `S_CHAR_LEN`.
  - At `S_CHAR_LEN` the character is complete and the counter wraps to 0 for back-to-back characters.
- **Character completion**
  - If `S_RX_VALID`=0, the character is written to RX and `S_RX_VALID` sets.
  - If `S_RX_VALID`=1, the new character is dropped, the old one is kept, and `S_OVERRUN` pulses.
  - If the consumer takes the old character (`S_RX_READY`=1) in the same cycle that a new one completes, the new character is stored and there is no overrun.
- **TX handshake**: a transfer happens when `S_TX_VALID`=1 and `S_TX_READY`=1. A TX write in the same cycle as a load point is used by that load.
- **CS rising mid-character**
  - The partial RX character is discarded, the counter clears, and the TX shift contents are lost.
  - The TX holding register is untouched and no flag pulses.
- **Output enable**: `S_SPI_MISO_OE` = ACTIVE. When OE=0, MISO is 1.
- **`S_CHAR_LEN` changes**: the value is sampled only in IDLE. Changes during ACTIVE take effect at the next frame.

## Timing
- **Reset values**
  - `S_SPI_MISO`=1, `S_SPI_MISO_OE`=0, `S_TX_READY`=1.
  - `S_RX_DATA`=0, `S_RX_VALID`=0, `S_OVERRUN`=0, `S_UNDERRUN`=0, `S_BUSY`=0.
- **Bus edge latency**: actions take effect `SYNC_STAGES`+1 `S_SYSCLK` cycles after the pin edge is first sampled. This covers the MISO update, sample capture and CS response.
- **RX latency**: `S_RX_VALID` rises `SYNC_STAGES`+1 cycles after the final sample edge. It falls in the cycle after the handshake.
- **TX latency**: `S_TX_READY` falls in the cycle after a TX handshake.
- **Bus timing requirement**: SCK high and low times must each be at least `SYNC_STAGES`+3 cycles. The CS_B-fall to first-SCK-edge setup must be at least the same.
- **Pulse outputs**: `S_OVERRUN` and `S_UNDERRUN` are exactly one cycle wide.
- **Reset priority**: a synchronous reset during a frame forces the reset values on the next edge. The block stays in IDLE until a fresh CS fall.

## Test plan
- **Mode 0, 8-bit exchange**: mode 0, `S_CHAR_LEN`=7, `S_REV`=1, TX 0xA5 preloaded; master sends 0x3C.
  → MISO 1,0,1,0,0,1,0,1; `S_RX_DATA`=0x003C; `S_RX_VALID` one char.
- **All modes, 16-bit**: modes 0–3, `S_CHAR_LEN`=15, TX 0x55AA, master sends 0xAA55.
  → master reads 0x55AA and slave reads 0xAA55 in every mode.
- **LSB first**: `S_REV`=0, `S_CHAR_LEN`=3, TX 0x1.
  → MISO 1,0,0,0; master sends 0x8 → `S_RX_DATA`=0x0008.
- **Overrun**: two back-to-back 8-bit characters 0x11 and 0x22 in one CS frame, `S_RX_READY`=0.
  → `S_OVERRUN` pulses once; `S_RX_DATA` stays 0x0011.
- **Underrun**: TX empty at CS fall.
  → `S_UNDERRUN` pulses once; MISO all ones; `S_TX_READY` stays 1.
- **Abort and reset**: CS_B rises after 3 bits.
  → no `S_RX_VALID`; the next full frame is correct.
  - Assert `S_RESET` mid-frame → all outputs return to their reset values on the next cycle.

Source files
------------

// File: rtl/spi_slave_trx.sv
// SPI target endpoint: oversampled SCK/MOSI/CS_B, all four CPOL/CPHA modes, 4-16 bit characters,
// one-deep TX/RX holding registers with valid/ready handshakes and overrun/underrun pulses.
`timescale 1ns/1ps
module spi_slave_trx #(
    parameter int unsigned CHAR_NBITS  = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  S_SYSCLK,
    input  logic                  S_RESET,
    input  logic                  S_ENABLE,
    input  logic                  S_CPOL,
    input  logic                  S_CPHA,
    input  logic                  S_REV,
    input  logic [3:0]            S_CHAR_LEN,
    input  logic                  S_SPI_SCK,
    input  logic                  S_SPI_MOSI,
    input  logic                  S_SPI_CS_B,
    output logic                  S_SPI_MISO,
    output logic                  S_SPI_MISO_OE,
    input  logic [CHAR_NBITS-1:0] S_TX_DATA,
    input  logic                  S_TX_VALID,
    output logic                  S_TX_READY,
    output logic [CHAR_NBITS-1:0] S_RX_DATA,
    output logic                  S_RX_VALID,
    input  logic                  S_RX_READY,
    output logic                  S_OVERRUN,
    output logic                  S_UNDERRUN,
    output logic                  S_BUSY
);
    typedef enum logic {ST_IDLE, ST_ACTIVE} state_t;

    state_t                  r_state;
    logic [SYNC_STAGES-1:0]  r_sck_sync, r_mosi_sync, r_csb_sync;
    logic                    r_sck_d, r_csb_d;
    logic [3:0]              r_len, r_bitcnt;
    logic [CHAR_NBITS-1:0]   r_txsh, r_rxsh, r_tx_hold, r_rx_data;
    logic                    r_tx_full, r_rx_valid, r_miso, r_overrun, r_underrun;

    logic                    w_sck, w_mosi, w_csb;
    logic                    w_lead, w_trail, w_sample, w_shift, w_cs_fall, w_cs_rise;
    logic                    w_tx_xfer, w_tx_empty, w_load, w_load_bit, w_shift_bit, w_complete;
    logic [3:0]              w_len;
    logic [CHAR_NBITS-1:0]   w_tx_src, w_txsh_next, w_rx_next;

    // Synchronizers track the pins only; leaving them out of reset keeps a CS_B held low
    // through reset from looking like a fresh falling edge afterwards.
    always_ff @(posedge S_SYSCLK) begin
        r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], S_SPI_SCK};
        r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], S_SPI_MOSI};
        r_csb_sync  <= {r_csb_sync[SYNC_STAGES-2:0], S_SPI_CS_B};
        r_sck_d     <= w_sck;
        r_csb_d     <= w_csb;
    end

    assign w_sck     = r_sck_sync[SYNC_STAGES-1];
    assign w_mosi    = r_mosi_sync[SYNC_STAGES-1];
    assign w_csb     = r_csb_sync[SYNC_STAGES-1];
    assign w_lead    = (w_sck != S_CPOL) && (r_sck_d == S_CPOL);
    assign w_trail   = (w_sck == S_CPOL) && (r_sck_d != S_CPOL);
    assign w_sample  = S_CPHA ? w_trail : w_lead;
    assign w_shift   = S_CPHA ? w_lead : w_trail;
    assign w_cs_fall = !w_csb && r_csb_d;
    assign w_cs_rise = w_csb && !r_csb_d;

    assign w_len      = (r_state == ST_IDLE) ? S_CHAR_LEN : r_len;
    assign w_tx_xfer  = S_TX_VALID && !r_tx_full;
    assign w_tx_empty = !r_tx_full && !w_tx_xfer;
    assign w_tx_src   = r_tx_full ? r_tx_hold : (w_tx_xfer ? S_TX_DATA : '1);
    assign w_load_bit = S_REV ? w_tx_src[w_len] : w_tx_src[0];
    assign w_txsh_next = S_REV ? (r_txsh << 1) : (r_txsh >> 1);
    assign w_shift_bit = S_REV ? w_txsh_next[r_len] : w_txsh_next[0];
    assign w_complete  = w_sample && (r_bitcnt == r_len);

    // A shift edge with the bit counter at zero is always a character's first shift edge:
    // in CPHA=0 the first character is loaded at CS fall instead, so a zero-count trailing edge
    // only occurs right after a completed character.
    assign w_load = (r_state == ST_IDLE)
                  ? (S_ENABLE && w_cs_fall && !S_CPHA)
                  : (S_ENABLE && !w_cs_rise && w_shift && (r_bitcnt == 4'd0));

    always_comb begin
        w_rx_next = r_rxsh;
        if (S_REV) w_rx_next = {r_rxsh[CHAR_NBITS-2:0], w_mosi};
        else       w_rx_next[r_bitcnt] = w_mosi;
    end

    always_ff @(posedge S_SYSCLK) begin
        if (S_RESET) begin
            r_state    <= ST_IDLE;
            r_len      <= '0;
            r_bitcnt   <= '0;
            r_txsh     <= '0;
            r_rxsh     <= '0;
            r_tx_hold  <= '0;
            r_tx_full  <= 1'b0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_miso     <= 1'b1;
            r_overrun  <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_overrun  <= 1'b0;
            r_underrun <= 1'b0;
            if (r_rx_valid && S_RX_READY) r_rx_valid <= 1'b0;
            if (w_tx_xfer) begin
                r_tx_hold <= S_TX_DATA;
                r_tx_full <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    r_len    <= S_CHAR_LEN;
                    r_miso   <= 1'b1;
                    r_bitcnt <= '0;
                    r_rxsh   <= '0;
                    if (S_ENABLE && w_cs_fall) r_state <= ST_ACTIVE;
                end
                ST_ACTIVE: begin
                    if (!S_ENABLE || w_cs_rise) begin
                        r_state  <= ST_IDLE;
                        r_miso   <= 1'b1;
                        r_bitcnt <= '0;
                        r_rxsh   <= '0;
                    end else begin
                        if (w_shift && (r_bitcnt != 4'd0)) begin
                            r_txsh <= w_txsh_next;
                            r_miso <= w_shift_bit;
                        end
                        if (w_complete) begin
                            r_bitcnt <= '0;
                            r_rxsh   <= '0;
                            if (!r_rx_valid || S_RX_READY) begin
                                r_rx_data  <= w_rx_next;
                                r_rx_valid <= 1'b1;
                            end else begin
                                r_overrun <= 1'b1;
                            end
                        end else if (w_sample) begin
                            r_bitcnt <= r_bitcnt + 4'd1;
                            r_rxsh   <= w_rx_next;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
            // A TX write coincident with a load is consumed by it, so the full flag stays clear.
            if (w_load) begin
                r_txsh     <= w_tx_src;
                r_miso     <= w_load_bit;
                r_tx_full  <= 1'b0;
                r_underrun <= w_tx_empty;
            end
            if (!S_ENABLE) begin
                r_tx_full  <= 1'b0;
                r_rx_valid <= 1'b0;
            end
        end
    end

    assign S_SPI_MISO    = r_miso;
    assign S_SPI_MISO_OE = (r_state == ST_ACTIVE);
    assign S_BUSY        = (r_state == ST_ACTIVE) && !w_csb;
    assign S_TX_READY    = !r_tx_full;
    assign S_RX_DATA     = r_rx_data;
    assign S_RX_VALID    = r_rx_valid;
    assign S_OVERRUN     = r_overrun;
    assign S_UNDERRUN    = r_underrun;
endmodule

// File: tb/tb_spi_slave_trx.sv
// Bench for spi_slave_trx: a bit-banged SPI master drives directed frames; expected RX characters
// are queued by the stimulus and checked by an independent monitor on the RX handshake.
`timescale 1ns/1ps
module tb_spi_slave_trx;
    localparam int HALF = 8;

    logic        clk = 1'b0;
    logic        S_RESET = 1'b1, S_ENABLE = 1'b1, S_CPOL = 1'b0, S_CPHA = 1'b0, S_REV = 1'b1;
    logic [3:0]  S_CHAR_LEN = 4'd7;
    logic        S_SPI_SCK = 1'b0, S_SPI_MOSI = 1'b0, S_SPI_CS_B = 1'b1;
    logic        S_SPI_MISO, S_SPI_MISO_OE;
    logic [15:0] S_TX_DATA = '0;
    logic        S_TX_VALID = 1'b0, S_TX_READY;
    logic [15:0] S_RX_DATA;
    logic        S_RX_VALID, S_RX_READY = 1'b1;
    logic        S_OVERRUN, S_UNDERRUN, S_BUSY;

    int          n_vec = 0, n_bad = 0;
    int          ovr_cnt = 0, und_cnt = 0;
    logic [15:0] exp_rx[$];

    always #5 clk = ~clk;

    spi_slave_trx #(.CHAR_NBITS(16), .SYNC_STAGES(2)) dut (
        .S_SYSCLK(clk), .S_RESET(S_RESET), .S_ENABLE(S_ENABLE), .S_CPOL(S_CPOL), .S_CPHA(S_CPHA),
        .S_REV(S_REV), .S_CHAR_LEN(S_CHAR_LEN), .S_SPI_SCK(S_SPI_SCK), .S_SPI_MOSI(S_SPI_MOSI),
        .S_SPI_CS_B(S_SPI_CS_B), .S_SPI_MISO(S_SPI_MISO), .S_SPI_MISO_OE(S_SPI_MISO_OE),
        .S_TX_DATA(S_TX_DATA), .S_TX_VALID(S_TX_VALID), .S_TX_READY(S_TX_READY),
        .S_RX_DATA(S_RX_DATA), .S_RX_VALID(S_RX_VALID), .S_RX_READY(S_RX_READY),
        .S_OVERRUN(S_OVERRUN), .S_UNDERRUN(S_UNDERRUN), .S_BUSY(S_BUSY)
    );

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: counts pulse-high cycles and checks every accepted RX character against the queue.
    always @(negedge clk) begin
        if (S_OVERRUN)  ovr_cnt++;
        if (S_UNDERRUN) und_cnt++;
        if (S_RX_VALID && S_RX_READY && !S_RESET) begin
            if (exp_rx.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL rx_unexpected: got 0x%0h, expected no character", S_RX_DATA);
            end else begin
                check("rx_data", S_RX_DATA, exp_rx.pop_front());
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_mode(input logic cpol, input logic cpha, input logic rev, input logic [3:0] len);
        S_CPOL = cpol; S_CPHA = cpha; S_REV = rev; S_CHAR_LEN = len;
        S_SPI_SCK = cpol;
        idle(4);
    endtask

    task automatic tx_write(input logic [15:0] d);
        int t = 0;
        while (!S_TX_READY && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!S_TX_READY) check("tx_ready_timeout", S_TX_READY, 16'h1);
        S_TX_DATA = d; S_TX_VALID = 1'b1;
        @(negedge clk);
        S_TX_VALID = 1'b0;
    endtask

    // Master side: clocks nclk bits of an nb-bit character and captures MISO at its sample edges.
    task automatic spi_bits(input logic [15:0] mo, input int nb, input int nclk, output logic [15:0] mi);
        int b;
        mi = '0;
        for (int i = 0; i < nclk; i++) begin
            b = S_REV ? (nb - 1 - i) : i;
            if (!S_CPHA) begin
                S_SPI_MOSI = mo[b];
                idle(HALF);
                mi[b] = S_SPI_MISO;
                S_SPI_SCK = ~S_CPOL;
                idle(HALF);
                S_SPI_SCK = S_CPOL;
            end else begin
                S_SPI_SCK = ~S_CPOL;
                S_SPI_MOSI = mo[b];
                idle(HALF);
                mi[b] = S_SPI_MISO;
                S_SPI_SCK = S_CPOL;
                idle(HALF);
            end
        end
    endtask

    task automatic cs_low;
        S_SPI_CS_B = 1'b0;
        idle(HALF);
    endtask

    task automatic cs_high;
        idle(HALF);
        S_SPI_CS_B = 1'b1;
        idle(2 * HALF);
    endtask

    task automatic frame1(input logic [15:0] mo, input logic [15:0] exp_mi, input int nb, input string nm);
        logic [15:0] mi;
        cs_low;
        check({nm, "_busy"}, S_BUSY, 16'h1);
        check({nm, "_oe"}, S_SPI_MISO_OE, 16'h1);
        spi_bits(mo, nb, nb, mi);
        cs_high;
        check({nm, "_miso"}, mi, exp_mi);
    endtask

    task automatic drain;
        int t = 0;
        while (exp_rx.size() != 0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("rx_drain", exp_rx.size(), 16'h0);
    endtask

    task automatic check_reset_outputs(input string nm);
        check({nm, "_miso"}, S_SPI_MISO, 16'h1);
        check({nm, "_oe"}, S_SPI_MISO_OE, 16'h0);
        check({nm, "_tx_ready"}, S_TX_READY, 16'h1);
        check({nm, "_rx_valid"}, S_RX_VALID, 16'h0);
        check({nm, "_busy"}, S_BUSY, 16'h0);
        check({nm, "_ovr"}, S_OVERRUN, 16'h0);
        check({nm, "_und"}, S_UNDERRUN, 16'h0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] mi0, mi1;
        int base_o, base_u;

        idle(3);
        S_RESET = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset");
        check("reset_rx_data", S_RX_DATA, 16'h0);

        // Mode 0, 8-bit MSB first
        set_mode(1'b0, 1'b0, 1'b1, 4'd7);
        tx_write(16'h00A5);
        check("tx_ready_low", S_TX_READY, 16'h0);
        exp_rx.push_back(16'h003C);
        frame1(16'h003C, 16'h00A5, 8, "m0_8b");
        drain;
        check("tx_ready_after", S_TX_READY, 16'h1);

        // All four modes, 16-bit
        for (int m = 0; m < 4; m++) begin
            set_mode(m[1], m[0], 1'b1, 4'd15);
            tx_write(16'h55AA);
            exp_rx.push_back(16'hAA55);
            frame1(16'hAA55, 16'h55AA, 16, "mode16");
            drain;
        end

        // LSB first, 4-bit
        set_mode(1'b0, 1'b0, 1'b0, 4'd3);
        tx_write(16'h0001);
        exp_rx.push_back(16'h0008);
        frame1(16'h0008, 16'h0001, 4, "lsb4");
        drain;

        // Overrun: two characters in one frame with the consumer stalled
        set_mode(1'b0, 1'b0, 1'b1, 4'd7);
        @(posedge clk); #1 S_RX_READY = 1'b0;
        base_o = ovr_cnt;
        exp_rx.push_back(16'h0011);
        cs_low;
        spi_bits(16'h0011, 8, 8, mi0);
        spi_bits(16'h0022, 8, 8, mi1);
        cs_high;
        check("ovr_miso0", mi0, 16'h00FF);
        check("ovr_miso1", mi1, 16'h00FF);
        check("ovr_pulses", ovr_cnt - base_o, 16'h1);
        check("ovr_rx_data", S_RX_DATA, 16'h0011);
        check("ovr_rx_valid", S_RX_VALID, 16'h1);
        @(posedge clk); #1 S_RX_READY = 1'b1;
        drain;

        // Underrun: TX empty, mode 1 so the single load point is the first shift edge
        set_mode(1'b0, 1'b1, 1'b1, 4'd7);
        base_u = und_cnt;
        exp_rx.push_back(16'h005A);
        frame1(16'h005A, 16'h00FF, 8, "und");
        drain;
        check("und_pulses", und_cnt - base_u, 16'h1);
        check("und_tx_ready", S_TX_READY, 16'h1);

        // Abort after 3 bits; holding register written mid-frame must survive
        set_mode(1'b0, 1'b0, 1'b1, 4'd7);
        tx_write(16'h00C3);
        base_o = ovr_cnt;
        cs_low;
        base_u = und_cnt;
        tx_write(16'h0096);
        spi_bits(16'h005A, 8, 3, mi0);
        cs_high;
        check("abort_rx_valid", S_RX_VALID, 16'h0);
        check("abort_tx_ready", S_TX_READY, 16'h0);
        check("abort_und", und_cnt - base_u, 16'h0);
        check("abort_ovr", ovr_cnt - base_o, 16'h0);
        exp_rx.push_back(16'h0069);
        frame1(16'h0069, 16'h0096, 8, "post_abort");
        drain;

        // Synchronous reset mid-frame
        tx_write(16'h00F0);
        cs_low;
        spi_bits(16'h00AB, 8, 2, mi0);
        S_RESET = 1'b1;
        @(negedge clk);
        S_RESET = 1'b0;
        check_reset_outputs("midreset");
        spi_bits(16'h00AB, 8, 6, mi0);
        check("midreset_oe_held", S_SPI_MISO_OE, 16'h0);
        cs_high;
        check("midreset_rx_valid", S_RX_VALID, 16'h0);
        tx_write(16'h000F);
        exp_rx.push_back(16'h00AB);
        frame1(16'h00AB, 16'h000F, 8, "post_reset");
        drain;

        idle(10);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
